conv_accumulator: RTL and testbench

//  Downstream of the fixed-point pixel*weight multiplier. Consumes a stream of Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT

---
 rtl/conv_accumulator.sv | 156 +++++++++++++++
 tb/tb_conv_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator
//  Description : Sums KERNEL_SIZE*KERNEL_SIZE signed fixed-point products per
//                output pixel, adds a bias sampled with the first term of the
//                window, saturates to DATA_WIDTH, optionally applies ReLU, and
//                presents one result per window on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int GUARD_BITS  = 4,
    parameter int RELU        = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] product,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_sat
);

    // Window geometry and accumulator sizing.
    localparam int c_n         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_cnt_w     = (c_n > 2) ? $clog2(c_n) : 1;
    localparam int c_acc_w     = DATA_WIDTH + GUARD_BITS;
    localparam int c_frac_bits = FRAC_BIT;  // Q format is shared by inputs and result, so no rescale

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n - 1);

    // Clamp limits expressed at accumulator width.
    localparam logic signed [c_acc_w-1:0] c_sum_max =
        {{(GUARD_BITS + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_sum_min =
        {{(GUARD_BITS + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_out_max = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_out_min = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    // State registers.
    logic signed [c_acc_w-1:0]    acc_q,       acc_d;
    logic        [c_cnt_w-1:0]    count_q,     count_d;
    logic        [DATA_WIDTH-1:0] bias_q,      bias_d;
    logic                         out_valid_q, out_valid_d;
    logic        [DATA_WIDTH-1:0] out_q,       out_d;
    logic                         out_sat_q,   out_sat_d;

    // Combinational datapath.
    logic                         w_accept;
    logic                         w_is_first;
    logic                         w_is_last;
    logic signed [c_acc_w-1:0]    w_prod_ext;
    logic signed [c_acc_w-1:0]    w_bias_ext;
    logic signed [c_acc_w-1:0]    w_sum;
    logic        [DATA_WIDTH-1:0] w_sat_val;
    logic                         w_sat_flag;
    logic        [DATA_WIDTH-1:0] w_result;

    // Only the closing term of a window needs a free output slot.
    assign w_is_first = (count_q == '0);
    assign w_is_last  = (count_q == c_cnt_last);
    assign in_ready   = ~w_is_last | ~out_valid_q | out_ready;
    assign w_accept   = in_valid & in_ready;

    assign w_prod_ext = {{GUARD_BITS{product[DATA_WIDTH-1]}}, product};
    assign w_bias_ext = {{GUARD_BITS{bias_q[DATA_WIDTH-1]}}, bias_q};
    assign w_sum      = acc_q + w_prod_ext + w_bias_ext;

    // Clamp the full-precision window sum into the output range.
    always_comb begin
        w_sat_val  = w_sum[DATA_WIDTH-1:0];
        w_sat_flag = 1'b0;
        if (w_sum > c_sum_max) begin
            w_sat_val  = c_out_max;
            w_sat_flag = 1'b1;
        end else if (w_sum < c_sum_min) begin
            w_sat_val  = c_out_min;
            w_sat_flag = 1'b1;
        end
    end

    // Optional rectification after saturation; the saturation flag is untouched.
    generate
        if (RELU != 0) begin : g_relu
            assign w_result = w_sat_val[DATA_WIDTH-1] ? '0 : w_sat_val;
        end else begin : g_no_relu
            assign w_result = w_sat_val;
        end
    endgenerate

    // Next-state: term accumulation, window closing and output slot handshake.
    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        bias_d      = bias_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_accept) begin
            if (w_is_first) begin
                acc_d   = w_prod_ext;
                bias_d  = bias;
                count_d = c_cnt_w'(1);
            end else if (w_is_last) begin
                // A result drained in this same cycle is replaced without a bubble.
                out_d       = w_result;
                out_sat_d   = w_sat_flag;
                out_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
            end else begin
                acc_d   = acc_q + w_prod_ext;
                count_d = count_q + c_cnt_w'(1);
            end
        end
    end

    // State update with asynchronous reset discarding partial and held results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            count_q     <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            bias_q      <= bias_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_sat   = out_sat_q;

    // Parameter is descriptive only; keep it referenced.
    logic w_unused_frac;
    assign w_unused_frac = (c_frac_bits < 0);

endmodule
`default_nettype wire

// File: tb/tb_conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_accumulator
//  Description : Directed and randomized checks of conv_accumulator against a
//                window-level arithmetic reference (RELU=0 and RELU=1 copies).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_accumulator;

    localparam int DW = 16;
    localparam int N  = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready, in_ready_r;
    logic [DW-1:0] product;
    logic [DW-1:0] bias;
    logic          out_valid, out_valid_r;
    logic          out_ready;
    logic [DW-1:0] out, out_r;
    logic          out_sat, out_sat_r;

    always #5 clk = ~clk;

    conv_accumulator #(.DATA_WIDTH(16), .FRAC_BIT(8), .KERNEL_SIZE(3), .GUARD_BITS(4), .RELU(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_sat(out_sat)
    );

    conv_accumulator #(.DATA_WIDTH(16), .FRAC_BIT(8), .KERNEL_SIZE(3), .GUARD_BITS(4), .RELU(1)) dut_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .product(product), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
        .out(out_r), .out_sat(out_sat_r)
    );

    typedef struct {
        logic [DW-1:0] o;
        logic          sat;
        logic [DW-1:0] o_relu;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rx    = 0;
    int   n_win   = 0;

    // Reference model: collect terms, close window with plain integer arithmetic.
    int   m_cnt  = 0;
    int   m_sum  = 0;
    int   m_bias = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_term(input logic [DW-1:0] p, input logic [DW-1:0] b);
        exp_t e;
        int   total;
        if (m_cnt == 0) begin
            m_bias = sx(b);
            m_sum  = 0;
        end
        m_sum += sx(p);
        m_cnt++;
        if (m_cnt == N) begin
            total = m_sum + m_bias;
            if (total > 32767) begin
                e.o = 16'h7FFF; e.sat = 1'b1;
            end else if (total < -32768) begin
                e.o = 16'h8000; e.sat = 1'b1;
            end else begin
                e.o = total[DW-1:0]; e.sat = 1'b0;
            end
            e.o_relu = (total < 0) ? 16'h0000 : e.o;
            exp_q.push_back(e);
            n_win++;
            m_cnt = 0;
        end
    endtask

    // One clock: observe handshakes mid-cycle, update model, advance past the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out", 32'(out), 32'(e.o));
                chk("out_sat", 32'(out_sat), 32'(e.sat));
                chk("out_relu", 32'(out_r), 32'(e.o_relu));
                chk("out_sat_relu", 32'(out_sat_r), 32'(e.sat));
                n_rx++;
            end
        end
        if (in_valid && in_ready) model_term(product, bias);
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] p, input logic [DW-1:0] b);
        in_valid = 1'b1;
        product  = p;
        bias     = b;
        cycle();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        m_cnt = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset     = 1'b0;
        in_valid  = 1'b0;
        product   = '0;
        bias      = '0;
        out_ready = 1'b1;
        #2;
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: nine unit terms, result one cycle after the ninth accept
        for (int i = 0; i < N; i++) begin
            chk("t1_no_early_valid", 32'(out_valid), 32'd0);
            feed(16'h0100, 16'h0000);
        end
        chk("t1_latency_valid", 32'(out_valid), 32'd1);
        chk("t1_out", 32'(out), 32'h0900);
        idle();

        // 2: mixed signs plus bias
        for (int i = 0; i < 4; i++) feed(16'h0200, (i == 0) ? 16'h0080 : 16'h1234);
        for (int i = 0; i < 5; i++) feed(16'hFF00, 16'h7777);
        chk("t2_out", 32'(out), 32'h0380);
        chk("t2_sat", 32'(out_sat), 32'd0);
        idle();

        // 3: positive and negative saturation, with and without ReLU
        for (int i = 0; i < N; i++) feed(16'h7000, 16'h0000);
        chk("t3_pos_out", 32'(out), 32'h7FFF);
        chk("t3_pos_sat", 32'(out_sat), 32'd1);
        idle();
        for (int i = 0; i < N; i++) feed(16'h9000, 16'h0000);
        chk("t3_neg_out", 32'(out), 32'h8000);
        chk("t3_neg_sat", 32'(out_sat), 32'd1);
        chk("t3_neg_relu_out", 32'(out_r), 32'h0000);
        chk("t3_neg_relu_sat", 32'(out_sat_r), 32'd1);
        idle();

        // 4: backpressure on the last term of a following window
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) feed(16'h0100, 16'h0000);
        for (int i = 0; i < N - 1; i++) begin
            chk("t4_ready_mid", 32'(in_ready), 32'd1);
            feed(16'h0200, 16'h0000);
        end
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_ready", 32'(in_ready), 32'd0);
            chk("t4_held_out", 32'(out), 32'h0900);
            feed(16'h0200, 16'h0000);
        end
        out_ready = 1'b1;
        feed(16'h0200, 16'h0000);
        chk("t4_no_bubble_valid", 32'(out_valid), 32'd1);
        chk("t4_second_out", 32'(out), 32'h1200);
        idle();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // 5: reset mid-window with a result held
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) feed(16'h0300, 16'h0000);
        for (int i = 0; i < 4; i++) feed(16'h0100, 16'h0000);
        do_reset();
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) feed(16'h0100, 16'h0000);
        chk("t5_clean_out", 32'(out), 32'h0900);
        idle();

        // 6: randomized gaps, backpressure and per-cycle bias changes
        n_win = 0;
        n_rx  = 0;
        guard = 0;
        while (n_win < 100 && guard < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            bias      = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       product = 16'($urandom);
                1:       product = 16'($urandom_range(0, 16'h0FFF));
                2:       product = 16'(-$urandom_range(0, 16'h0FFF));
                default: product = $urandom_range(0, 1) ? 16'h7F00 : 16'h8100;
            endcase
            cycle();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t6_windows_done", 32'(n_win), 32'd100);
        chk("t6_results_rx", 32'(n_rx), 32'd100);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
